// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte requesters, the arbiter and the UART transmitter.
//
// Handshake rules:
//   req[i]/req_data  : level "valid" from requester i. Hold req high with stable
//                      data until grant[i] pulses; grant[i] is the one-cycle
//                      acceptance.
//   tx_send/tx_busy  : tx_send is a level "valid" toward the transmitter, held
//                      until tx_busy (baud domain) is seen high through the
//                      synchronizer; tx_data is stable from grant to next grant.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_send;
  logic                      tx_busy;

  // Requesters plus transmitter side
  modport master (output req, req_data, tx_busy, input grant, tx_data, tx_send);
  // Arbiter side
  modport slave  (input req, req_data, tx_busy, output grant, tx_data, tx_send);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// requesters, with start timeout and an enforced inter-frame gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_W        = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 65535,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic            src_clk,
  input  logic            rst_n,
  input  logic            enable,
  uart_tx_arbiter_if.slave bus,
  output logic [ID_W-1:0] active_id,
  output logic            busy,
  output logic            err_timeout,
  output logic [1:0]      state_dbg
);

  localparam int TO_W  = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               busy_ff1, busy_s;
  logic [1:0]         sync_fill;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [DATA_W-1:0]  tx_data_n;
  logic               tx_send_n;
  logic [ID_W-1:0]    active_id_n;
  logic               err_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  int                 scan_idx;

  // Two-flop synchronizer for tx_busy; sync_fill marks when busy_s carries a
  // real sample after reset, so a Tx still busy from before reset is not missed.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_ff1  <= 1'b0;
      busy_s    <= 1'b0;
      sync_fill <= 2'b00;
    end else begin
      busy_ff1  <= bus.tx_busy;
      busy_s    <= busy_ff1;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Round-robin scan: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!pick_found && bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(scan_idx);
      end
    end
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    grant_n     = '0;
    tx_data_n   = bus.tx_data;
    tx_send_n   = bus.tx_send;
    active_id_n = active_id;
    err_n       = err_timeout;
    to_cnt_n    = to_cnt;
    gap_cnt_n   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (enable && pick_found && !busy_s && sync_fill[1]) begin
          grant_n     = NUM_REQ'(1) << pick_idx;
          tx_data_n   = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
          active_id_n = pick_idx;
          rr_ptr_n    = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          tx_send_n   = 1'b1;
          to_cnt_n    = '0;
          state_n     = S_SEND;
        end
      end
      S_SEND: begin
        if (busy_s) begin
          tx_send_n = 1'b0;
          state_n   = S_WAIT_DONE;
        end else if (to_cnt == TO_W'(START_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the frame, no retry.
          err_n     = 1'b1;
          tx_send_n = 1'b0;
          gap_cnt_n = '0;
          state_n   = S_GAP;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!busy_s) begin
          gap_cnt_n = '0;
          state_n   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_n = S_IDLE;
        else gap_cnt_n = gap_cnt + GAP_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      bus.grant   <= '0;
      bus.tx_data <= '0;
      bus.tx_send <= 1'b0;
      active_id   <= '0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      bus.grant   <= grant_n;
      bus.tx_data <= tx_data_n;
      bus.tx_send <= tx_send_n;
      active_id   <= active_id_n;
      err_timeout <= err_n;
      to_cnt      <= to_cnt_n;
      gap_cnt     <= gap_cnt_n;
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte requesters, for example the manual-switch byte and the RX echo/loopback byte.
- Round-robin arbitration; captures the granted byte and drives the transmitter's send strobe.
- Tracks transmitter busy (crossing from the slow baud domain) and enforces an inter-frame gap.
- Sits between the requesters and the Tx, replacing the direct push-button/mux path.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width.
- GAP_CYCLES, 16, src_clk idle cycles enforced after each frame before the next arbitration (>=1).
- START_TIMEOUT, 65535, max src_clk cycles to wait for tx_busy to rise after tx_send asserts.

Ports:
- src_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = arbitration allowed; 0 = no new grants (baud-rate configuration mode).
- req  in  NUM_REQ  per-requester level request; must hold with stable data until granted.
- req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i captured.
- tx_data  out  DATA_W  registered byte to transmitter; stable from grant until next grant.
- tx_send  out  1  send strobe to Tx; level, held until busy acknowledged.
- tx_busy  in  1  Tx busy, asynchronous to src_clk (baud domain).
- active_id  out  clog2(NUM_REQ) (min 1)  index of last granted requester.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky; set on start timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state IDLE; grant=0, tx_send=0, tx_data=0, active_id=0, busy=0, err_timeout=0; rr_ptr=0; gap/timeout counters=0; synchronizer flops=0.
- tx_busy passes through a 2-flop synchronizer to busy_s. All decisions use busy_s only.
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
- IDLE, when enable=1, |req=1 and busy_s=0:
  - Pick the first asserted req scanning upward from rr_ptr, with wrap-around.
  - At that edge register grant[i]=1 (one cycle), tx_data=req_data[i], active_id=i, rr_ptr=(i+1) mod NUM_REQ.
  - Go to SEND.
  - Latency: req high at edge N produces grant high during cycle N+1.
- IDLE with enable=0, no req, or busy_s=1: stay in IDLE; nothing changes.
- SEND:
  - tx_send=1 and the timeout counter increments each cycle.
  - busy_s=1: tx_send=0 next cycle, go to WAIT_DONE.
  - Counter reaches START_TIMEOUT: set err_timeout, tx_send=0, go to GAP (frame dropped, no retry).
- WAIT_DONE: tx_send=0; stay until busy_s=0, then go to GAP with gap counter cleared.
- GAP: count GAP_CYCLES cycles, then go to IDLE. The next grant is possible on the first IDLE cycle.
- Simultaneous requests: exactly one grant per frame; the granted requester gets lowest priority next round.
- A req that drops before its grant is simply not served; no partial state is kept.
- enable falling mid-frame: the in-flight frame completes through SEND/WAIT_DONE/GAP; only new grants are blocked.
- grant is never asserted outside the IDLE→SEND transition cycle, and never more than one bit at a time.
- tx_data never changes while in SEND or WAIT_DONE.
- Reset mid-frame: all outputs return to reset values immediately. The Tx may finish its current frame; a subsequent arbitration waits in IDLE until busy_s=0.

Test Plan:
- Single request: rst_n release, enable=1, req=01, req_data[7:0]=0x41; Tx model raises busy 20 cycles after send, holds 100 cycles.
  - Required: grant=01 for exactly 1 cycle, 1 cycle after req.
  - Required: tx_data=0x41; tx_send high until busy_s=1.
  - Required: busy drops 16 cycles after busy_s falls.
- Contention: req=11 held; bytes 0x11 (req0) and 0x22 (req1).
  - Required: grants alternate 01,10,01,10; tx_data sequence 0x11,0x22,0x11,0x22.
  - Required: each next grant no earlier than GAP_CYCLES after frame end.
- Timeout: START_TIMEOUT=50, Tx busy stuck 0, req=01.
  - Required: tx_send high 50 cycles, then low; err_timeout=1 and stays 1.
  - Required: a new grant is issued after GAP.
- Enable gating: enable=0, req=10 for 200 cycles → no grant. Then enable=1 → grant=10 within 1 cycle.
  - Also drop enable mid-WAIT_DONE → frame completes, no further grant.
- Reset mid-frame: assert rst_n=0 during SEND.
  - Required: tx_send, grant, busy, err_timeout go to 0 asynchronously; rr_ptr=0.
  - Required: after release, with Tx busy still high, no grant until busy_s=0.
- Request withdrawn: req0 pulsed during WAIT_DONE and dropped before GAP ends → never granted; busy returns to 0 with grant always 0 for it.
